fb_writer: RTL and testbench

Pixel write buffer between the TIA video output and the framebuffer memory. Accepts single-cycle pixel writes (address, 16-bit colour), queues them in a small FIFO, and drains them to a req/ack framebuffer port. It drives `busy_o` back to the TIA so the beam-racing logic stalls instead of dropping pixels. It also performs a whole-framebuffer clear on request.

---
 rtl/fb_pkg.sv | 30 +++
 rtl/sync_fifo.sv | 52 +++++
 rtl/fb_writer.sv | 127 ++++++++++++
 tb/tb_fb_writer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared framebuffer definitions: writer state encoding, screen geometry, RGB565 pixel type.
package fb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_CLEAR = 2'd2
    } wr_state_e;

    localparam int FB_WIDTH  = 320;
    localparam int FB_HEIGHT = 240;
    localparam int FB_WORDS  = FB_WIDTH * FB_HEIGHT;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    // Truncate 8-bit channels down to RGB565.
    function automatic rgb565_t rgb565(input logic [7:0] r8, input logic [7:0] g8,
                                       input logic [7:0] b8);
        rgb565_t p;
        p.r = r8[7:3];
        p.g = g8[7:2];
        p.b = b8[7:3];
        return p;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO. Pointers carry one extra wrap bit so full and
// empty can be told apart without a separate counter register.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [AW:0]      wr_ptr_d, rd_ptr_d;
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    // A push into a full queue is dropped; a pop of an empty queue is a no-op.
    assign do_push  = push_i && !full_o;
    assign do_pop   = pop_i && !empty_o;
    assign wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
    assign rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);

    // Pointer registers; wrap naturally modulo 2*DEPTH.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/fb_writer.sv
// Pixel write buffer: queues TIA pixel writes and drains them to a req/ack
// framebuffer port, with a whole-framebuffer clear that preempts draining.
module fb_writer
    import fb_pkg::*;
#(
    parameter int ADDR_WIDTH = 17,
    parameter int PIX_WIDTH  = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int FB_WORDS   = fb_pkg::FB_WORDS
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  pix_wr_i,
    input  logic [ADDR_WIDTH-1:0] pix_addr_i,
    input  logic [PIX_WIDTH-1:0]  pix_data_i,
    output logic                  busy_o,
    input  logic                  clr_i,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [PIX_WIDTH-1:0]  mem_dat_o,
    input  logic                  mem_ack_i,
    output logic                  overflow_o
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int EW = ADDR_WIDTH + PIX_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(FB_WORDS - 1);
    localparam logic [CW-1:0]         BUSY_LVL  = CW'(FIFO_DEPTH - 2);

    wr_state_e             state_q;
    logic                  clr_pend_q;
    logic                  mem_req_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [PIX_WIDTH-1:0]  mem_dat_q;
    logic                  busy_q, busy_d;
    logic                  ovf_q;

    logic                  fifo_full, fifo_empty, fifo_pop, push_ok, clr_last;
    logic [CW-1:0]         fifo_count, count_d;
    logic [EW-1:0]         fifo_head;

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (pix_wr_i),
        .pop_i   (fifo_pop),
        .wdata_i ({pix_addr_i, pix_data_i}),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // The head entry stays queued while in flight; it leaves only on its ack.
    assign fifo_pop = (state_q == ST_WRITE) && mem_ack_i;
    assign push_ok  = pix_wr_i && !fifo_full;
    assign count_d  = fifo_count + CW'(push_ok) - CW'(fifo_pop);
    assign clr_last = (state_q == ST_CLEAR) && mem_ack_i && (mem_addr_q == LAST_WORD);

    // Busy after this edge: near-full queue, a clear still running, or one waiting to run.
    assign busy_d = (count_d >= BUSY_LVL) || clr_i || clr_pend_q ||
                    ((state_q == ST_CLEAR) && !clr_last);

    assign mem_req_o  = mem_req_q;
    assign mem_addr_o = mem_addr_q;
    assign mem_dat_o  = mem_dat_q;
    assign busy_o     = busy_q;
    assign overflow_o = ovf_q;

    // Drain/clear state machine with registered memory-port outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            clr_pend_q <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            mem_dat_q  <= '0;
            busy_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            busy_q <= busy_d;
            if (pix_wr_i && fifo_full) ovf_q <= 1'b1;

            case (state_q)
                ST_IDLE: begin
                    if (clr_pend_q) begin
                        // Pending flag is consumed here so a clr_i arriving
                        // mid-clear re-arms it and schedules another pass.
                        clr_pend_q <= 1'b0;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= '0;
                        mem_dat_q  <= '0;
                        state_q    <= ST_CLEAR;
                    end else if (!fifo_empty) begin
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= fifo_head[EW-1 -: ADDR_WIDTH];
                        mem_dat_q  <= fifo_head[PIX_WIDTH-1:0];
                        state_q    <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (mem_ack_i) begin
                        mem_req_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                ST_CLEAR: begin
                    if (clr_last) begin
                        mem_req_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end else if (mem_ack_i) begin
                        mem_addr_q <= mem_addr_q + 1'b1;
                    end
                end
                default: begin
                    mem_req_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase

            if (clr_i) clr_pend_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fb_writer.sv
// Self-checking bench for fb_writer: vector table, directed clear/reset
// sequences, and a randomized run against a queue-based reference model.
module tb_fb_writer;
    localparam int AW = 17;
    localparam int PW = 16;
    localparam int DEPTH = 8;
    localparam int WORDS = 16;

    logic          clk = 1'b0;
    logic          rst, pix_wr, clr, ack;
    logic [AW-1:0] pix_addr;
    logic [PW-1:0] pix_data;
    logic          busy_o, mem_req_o, overflow_o;
    logic [AW-1:0] mem_addr_o;
    logic [PW-1:0] mem_dat_o;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] log_a[$];
    logic [PW-1:0] log_d[$];

    always #5 clk = ~clk;

    fb_writer #(
        .ADDR_WIDTH (AW),
        .PIX_WIDTH  (PW),
        .FIFO_DEPTH (DEPTH),
        .FB_WORDS   (WORDS)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .pix_wr_i   (pix_wr),
        .pix_addr_i (pix_addr),
        .pix_data_i (pix_data),
        .busy_o     (busy_o),
        .clr_i      (clr),
        .mem_req_o  (mem_req_o),
        .mem_addr_o (mem_addr_o),
        .mem_dat_o  (mem_dat_o),
        .mem_ack_i  (ack),
        .overflow_o (overflow_o)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [PW-1:0] dat;
        int            ack_dly;
        logic [AW-1:0] exp_addr;
        logic [PW-1:0] exp_dat;
        int            exp_lat;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; pix_wr = 1'b0; clr = 1'b0; ack = 1'b0;
        pix_addr = '0; pix_data = '0;
        step(); step();
        rst = 1'b0;
        step();
    endtask

    // Acknowledge every request after `delay` idle cycles, logging each
    // completed transaction, until the port has been quiet for 4 cycles.
    task automatic serve(input int delay, input int budget);
        int idle = 0;
        int wc = 0;
        log_a.delete(); log_d.delete();
        for (int c = 0; c < budget && idle < 4; c++) begin
            if (mem_req_o) begin
                idle = 0;
                if (wc >= delay) begin
                    ack = 1'b1;
                    log_a.push_back(mem_addr_o);
                    log_d.push_back(mem_dat_o);
                    wc = 0;
                end else wc++;
            end else idle++;
            step();
            ack = 1'b0;
        end
        chk("serve_quiesced", 64'(idle >= 4), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        vec_t tv[4];
        int lat, w, bad, stall;
        logic [AW+PW-1:0] q[$];
        logic ov_exp, wr, fire, full;
        int wrp, ackp;

        tv[0] = '{17'h00123, 16'hF800, 0, 17'h00123, 16'hF800, 2};
        tv[1] = '{17'h1FFFF, 16'hFFFF, 3, 17'h1FFFF, 16'hFFFF, 2};
        tv[2] = '{17'h00000, 16'h0000, 1, 17'h00000, 16'h0000, 2};
        tv[3] = '{17'h0AAAA, 16'h5555, 7, 17'h0AAAA, 16'h5555, 2};

        // Reset values
        rst = 1'b1; pix_wr = 1'b0; clr = 1'b0; ack = 1'b0;
        pix_addr = '0; pix_data = '0;
        step(); step();
        chk("rst_req", 64'(mem_req_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_ovf", 64'(overflow_o), 64'd0);
        chk("rst_addr", 64'(mem_addr_o), 64'd0);
        chk("rst_dat", 64'(mem_dat_o), 64'd0);
        rst = 1'b0;
        step();

        // Single writes: latency, stable hold during ack wait, empty afterwards
        for (int i = 0; i < 4; i++) begin
            pix_wr = 1'b1; pix_addr = tv[i].addr; pix_data = tv[i].dat;
            step();
            pix_wr = 1'b0;
            lat = 1;
            while (!mem_req_o && lat < 10) begin step(); lat++; end
            chk("vec_latency", 64'(lat), 64'(tv[i].exp_lat));
            chk("vec_addr", 64'(mem_addr_o), 64'(tv[i].exp_addr));
            chk("vec_dat", 64'(mem_dat_o), 64'(tv[i].exp_dat));
            for (int d = 0; d < tv[i].ack_dly; d++) begin
                step();
                chk("vec_hold", {mem_req_o, 15'd0, mem_dat_o, 15'd0, mem_addr_o},
                    {1'b1, 15'd0, tv[i].exp_dat, 15'd0, tv[i].exp_addr});
            end
            ack = 1'b1;
            step();
            ack = 1'b0;
            chk("vec_req_drop", 64'(mem_req_o), 64'd0);
            step();
            chk("vec_empty", {62'd0, busy_o, mem_req_o}, 64'd0);
        end

        // Burst of 9 strobes with acks withheld
        for (int i = 1; i <= 9; i++) begin
            pix_wr = 1'b1; pix_addr = AW'(32'h100 + i); pix_data = PW'(i * 32'h111);
            step();
            if (i == 5) chk("burst_busy5", 64'(busy_o), 64'd0);
            if (i == 6) chk("burst_busy6", 64'(busy_o), 64'd1);
            if (i == 8) chk("burst_ovf8", 64'(overflow_o), 64'd0);
            if (i == 9) chk("burst_ovf9", 64'(overflow_o), 64'd1);
        end
        pix_wr = 1'b0;
        repeat (20) step();
        chk("burst_head_wait", {mem_req_o, 15'd0, mem_addr_o}, {1'b1, 15'd0, 17'h101});
        serve(0, 100);
        chk("burst_count", 64'(log_a.size()), 64'd8);
        bad = 0;
        for (int i = 0; i < log_a.size() && i < 8; i++)
            if (log_a[i] !== AW'(32'h101 + i) || log_d[i] !== PW'((i + 1) * 32'h111)) bad++;
        chk("burst_order", 64'(bad), 64'd0);
        chk("burst_busy_after", 64'(busy_o), 64'd0);
        chk("burst_ovf_sticky", 64'(overflow_o), 64'd1);

        // Clear of 16 words with immediate acks
        do_reset();
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_busy_rise", 64'(busy_o), 64'd1);
        for (int i = 0; i < WORDS; i++) begin
            w = 0;
            while (!mem_req_o && w < 20) begin step(); w++; end
            chk("clr_word", {mem_req_o, busy_o, 14'd0, mem_dat_o, 15'd0, mem_addr_o},
                {2'b11, 14'd0, 16'd0, 15'd0, AW'(i)});
            ack = 1'b1;
            step();
            ack = 1'b0;
        end
        chk("clr_end", {62'd0, busy_o, mem_req_o}, 64'd0);
        bad = 0;
        repeat (5) begin step(); if (mem_req_o) bad++; end
        chk("clr_no_extra", 64'(bad), 64'd0);

        // Write enqueued during a clear drains after it
        clr = 1'b1; step(); clr = 1'b0;
        step(); step();
        pix_wr = 1'b1; pix_addr = 17'h5; pix_data = 16'h07E0;
        step();
        pix_wr = 1'b0;
        serve(0, 300);
        chk("clrwr_count", 64'(log_a.size()), 64'(WORDS + 1));
        bad = 0;
        for (int i = 0; i < WORDS && i < log_a.size(); i++)
            if (log_a[i] !== AW'(i) || log_d[i] !== '0) bad++;
        chk("clrwr_clear_seq", 64'(bad), 64'd0);
        if (log_a.size() > 0)
            chk("clrwr_last", {15'd0, log_d[$], 15'd0, log_a[$]}, {15'd0, 16'h07E0, 15'd0, 17'h5});

        // clr_i during an in-flight WRITE: write completes first
        pix_wr = 1'b1; pix_addr = 17'h0AB; pix_data = 16'h1234;
        step();
        pix_wr = 1'b0;
        step();
        chk("wrclr_inflight", 64'(mem_req_o), 64'd1);
        clr = 1'b1; step(); clr = 1'b0;
        serve(5, 400);
        chk("wrclr_count", 64'(log_a.size()), 64'(WORDS + 1));
        if (log_a.size() > 1) begin
            chk("wrclr_first", {15'd0, log_d[0], 15'd0, log_a[0]}, {15'd0, 16'h1234, 15'd0, 17'h0AB});
            chk("wrclr_clr0", {15'd0, log_d[1], 15'd0, log_a[1]}, 64'd0);
        end

        // Reset in the middle of a clear
        clr = 1'b1; step(); clr = 1'b0;
        w = 0;
        while (!(mem_req_o && mem_addr_o == 7) && w < 50) begin
            if (mem_req_o) ack = 1'b1;
            step();
            ack = 1'b0;
            w++;
        end
        chk("rstclr_reach7", {mem_req_o, 15'd0, mem_addr_o}, {1'b1, 15'd0, 17'h7});
        rst = 1'b1;
        #1;
        chk("rstclr_req_async", 64'(mem_req_o), 64'd0);
        step(); step();
        rst = 1'b0;
        bad = 0;
        repeat (6) begin step(); if (mem_req_o || busy_o) bad++; end
        chk("rstclr_quiet", 64'(bad), 64'd0);

        // Randomized run against a queue model of the write buffer
        do_reset();
        q.delete();
        ov_exp = 1'b0;
        stall = 0;
        for (int cyc = 0; cyc < 1600; cyc++) begin
            case ((cyc / 100) % 3)
                0: begin wrp = 50; ackp = 90; end
                1: begin wrp = 60; ackp = 0; end
                default: begin wrp = 30; ackp = 50; end
            endcase
            if (cyc >= 1500) begin wrp = 0; ackp = 100; end
            wr = (($urandom % 100) < wrp);
            pix_wr = wr;
            pix_addr = AW'($urandom);
            pix_data = PW'($urandom);
            ack = mem_req_o && (($urandom % 100) < ackp);
            fire = ack && mem_req_o;
            full = (q.size() == DEPTH);
            if (fire && q.size() != 0)
                chk("rnd_head", 64'({mem_addr_o, mem_dat_o}), 64'(q[0]));
            step();
            pix_wr = 1'b0;
            ack = 1'b0;
            if (fire && q.size() != 0) void'(q.pop_front());
            if (wr) begin
                if (full) ov_exp = 1'b1;
                else q.push_back({pix_addr, pix_data});
            end
            chk("rnd_busy", 64'(busy_o), 64'(q.size() >= DEPTH - 2));
            chk("rnd_ovf", 64'(overflow_o), 64'(ov_exp));
            chk("rnd_req_nonempty", 64'(mem_req_o && q.size() == 0), 64'd0);
            if (q.size() != 0 && !mem_req_o) stall++; else stall = 0;
            chk("rnd_stall", 64'(stall > 2), 64'd0);
        end
        chk("rnd_drained", 64'(q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
